// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative integer multiply/divide unit for the execute stage.
//
// MUL/MULW use one shift-add step per cycle, and DIV/REM use one
// restoring-subtract step per cycle. Word ops need 32 steps and full
// ops need 64. Division by zero and signed overflow skip the iterations
// and go from IDLE straight to DONE.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   valid_i   the execute-stage instruction is a mul/div op
//   op_i      0 MUL,1 MULW,2 DIV,3 DIVU,4 DIVW,5 DIVUW,6 REM,7 REMU,8 REMW,9 REMUW
//   a_i, b_i  forwarded source operands
//   flush_i   abort any operation in flight (highest priority)
//   stall_o   holds fetch/decode/execute while an operation is pending
//   done_o    result_o is valid this cycle (one-cycle pulse)
//   result_o  operation result; holds its value between operations
module muldiv_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg;
    logic [6:0]        count_reg;
    logic              is_mul_reg;
    logic              is_w_reg;
    logic              is_rem_reg;
    logic              q_neg_reg;
    logic              r_neg_reg;
    logic [XLEN-1:0]   p_reg;       // product accumulator / partial remainder
    logic [XLEN-1:0]   q_reg;       // multiplier / dividend-then-quotient
    logic [XLEN-1:0]   d_reg;       // multiplicand / divisor magnitude
    logic [XLEN-1:0]   result_reg;

    // Decode the incoming op.
    logic            op_is_mul, op_is_w, op_is_signed, op_is_rem, op_legal;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, special_raw, special_result;
    logic            a_neg, b_neg, div_by_zero, overflow, start;

    always_comb begin
        op_is_mul    = (op_i == 4'd0) || (op_i == 4'd1);
        op_is_w      = (op_i == 4'd1) || (op_i == 4'd4) || (op_i == 4'd5) ||
                       (op_i == 4'd8) || (op_i == 4'd9);
        op_is_signed = (op_i == 4'd2) || (op_i == 4'd4) || (op_i == 4'd6) || (op_i == 4'd8);
        op_is_rem    = (op_i >= 4'd6) && (op_i <= 4'd9);
        op_legal     = (op_i <= 4'd9);

        if (op_is_w) begin
            a_ext = op_is_signed ? {{32{a_i[31]}}, a_i[31:0]} : {32'd0, a_i[31:0]};
            b_ext = op_is_signed ? {{32{b_i[31]}}, b_i[31:0]} : {32'd0, b_i[31:0]};
        end else begin
            a_ext = a_i;
            b_ext = b_i;
        end

        a_neg = op_is_signed & a_ext[XLEN-1];
        b_neg = op_is_signed & b_ext[XLEN-1];
        a_mag = a_neg ? (~a_ext + 64'd1) : a_ext;
        b_mag = b_neg ? (~b_ext + 64'd1) : b_ext;

        min_val     = op_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_by_zero = ~op_is_mul & (b_ext == '0);
        overflow    = ~op_is_mul & op_is_signed & (a_ext == min_val) & (b_ext == '1);

        if (div_by_zero)
            special_raw = op_is_rem ? a_ext : '1;
        else
            special_raw = op_is_rem ? '0 : a_ext;
        special_result = op_is_w ? {{32{special_raw[31]}}, special_raw[31:0]} : special_raw;

        start = ~reset & (state_reg == IDLE) & valid_i & ~flush_i & op_legal;
    end

    // One iteration step plus the result that the final step produces.
    logic [XLEN-1:0] mul_acc, rem_next, quo_next, quo_fix, rem_fix, raw_result, final_result;
    logic [XLEN:0]   shifted;
    logic            ge;

    always_comb begin
        mul_acc  = p_reg + (q_reg[0] ? d_reg : '0);

        // The dividend bits shift out of the top of q_reg. For word ops the
        // dividend is loaded into the upper half so that 32 steps are enough.
        shifted  = {p_reg, q_reg[XLEN-1]};
        ge       = (shifted >= {1'b0, d_reg});
        rem_next = ge ? 64'(shifted - {1'b0, d_reg}) : shifted[XLEN-1:0];
        quo_next = {q_reg[XLEN-2:0], ge};

        quo_fix  = q_neg_reg ? (~quo_next + 64'd1) : quo_next;
        rem_fix  = r_neg_reg ? (~rem_next + 64'd1) : rem_next;

        if (is_mul_reg)
            raw_result = mul_acc;
        else
            raw_result = is_rem_reg ? rem_fix : quo_fix;
        final_result = is_w_reg ? {{32{raw_result[31]}}, raw_result[31:0]} : raw_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            is_mul_reg <= 1'b0;
            is_w_reg   <= 1'b0;
            is_rem_reg <= 1'b0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            p_reg      <= '0;
            q_reg      <= '0;
            d_reg      <= '0;
            result_reg <= '0;
        end else if (flush_i) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        is_mul_reg <= op_is_mul;
                        is_w_reg   <= op_is_w;
                        is_rem_reg <= op_is_rem;
                        q_neg_reg  <= a_neg ^ b_neg;
                        r_neg_reg  <= a_neg;
                        p_reg      <= '0;
                        if (op_is_mul) begin
                            // The low product bits do not depend on signedness.
                            q_reg <= b_ext;
                            d_reg <= a_ext;
                        end else begin
                            q_reg <= op_is_w ? {a_mag[31:0], 32'd0} : a_mag;
                            d_reg <= b_mag;
                        end
                        if (div_by_zero || overflow) begin
                            result_reg <= special_result;
                            count_reg  <= '0;
                            state_reg  <= DONE;
                        end else begin
                            count_reg <= op_is_w ? 7'd32 : 7'd64;
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (is_mul_reg) begin
                        p_reg <= mul_acc;
                        q_reg <= q_reg >> 1;
                        d_reg <= d_reg << 1;
                    end else begin
                        p_reg <= rem_next;
                        q_reg <= quo_next;
                    end
                    count_reg <= count_reg - 7'd1;
                    if (count_reg == 7'd1) begin
                        result_reg <= final_result;
                        state_reg  <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign stall_o  = ~reset & ~flush_i & (start | (state_reg == BUSY));
    assign done_o   = (state_reg == DONE) & ~flush_i;
    assign result_o = result_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl. Expected results come from a behavioural
// reference model. They go into a scoreboard queue when an op is issued
// and are popped and compared when done_o rises.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [3:0]  op_i;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [63:0] result_o;

    muldiv_ctrl #(.XLEN(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        logic [31:0] a32, b32, t32;
        logic [63:0] r;
        logic        ovf64, ovf32;
        sa = a; sb = b;
        a32 = a[31:0]; b32 = b[31:0];
        sa32 = a32; sb32 = b32;
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
        r = '0;
        case (op)
            4'd0: r = a * b;
            4'd1: begin t32 = a32 * b32; r = sx32(t32); end
            4'd2: if (b == 0) r = '1; else if (ovf64) r = a; else r = sa / sb;
            4'd3: if (b == 0) r = '1; else r = a / b;
            4'd4: if (b32 == 0) r = '1; else if (ovf32) r = sx32(a32);
                  else begin t32 = sa32 / sb32; r = sx32(t32); end
            4'd5: if (b32 == 0) r = '1; else begin t32 = a32 / b32; r = sx32(t32); end
            4'd6: if (b == 0) r = a; else if (ovf64) r = '0; else r = sa % sb;
            4'd7: if (b == 0) r = a; else r = a % b;
            4'd8: if (b32 == 0) r = sx32(a32); else if (ovf32) r = '0;
                  else begin t32 = sa32 % sb32; r = sx32(t32); end
            4'd9: if (b32 == 0) r = sx32(a32); else begin t32 = a32 % b32; r = sx32(t32); end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bit w, sgn, zero, ovf;
        w    = (op == 1) || (op == 4) || (op == 5) || (op == 8) || (op == 9);
        sgn  = (op == 2) || (op == 4) || (op == 6) || (op == 8);
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (op >= 2 && (zero || ovf)) return 1;
        return (w ? 32 : 64) + 1;
    endfunction

    // Called at posedge+1 with the unit idle, and returns at posedge+1.
    // valid_i stays high through DONE. The operands are scrambled while the
    // unit is busy, because the latched values must be the ones that count.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        exp_t got;
        int   cyc;
        int   stall_cnt;
        bit   seen;
        e.op = op; e.res = model(op, a, b); e.lat = latency(op, a, b);
        sb_q.push_back(e);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        #1;
        stall_cnt = stall_o ? 1 : 0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            a_i = {$urandom, $urandom};
            b_i = {$urandom, $urandom};
            #1;
            if (stall_o) stall_cnt++;
            if (done_o) begin
                seen = 1;
                got = sb_q.pop_front();
                check_val("result", result_o, got.res);
                check_val("done_cycle", 64'(cyc), 64'(got.lat));
                $display("op=%0d a=%h b=%h -> result=%h at cycle %0d", op, a, b, result_o, cyc);
            end
        end
        if (!seen) begin
            check_val("done_timeout", 64'd0, 64'd1);
            void'(sb_q.pop_front());
        end
        check_val("stall_cycles", 64'(stall_cnt), 64'(e.lat));
        valid_i = 1'b0;
        @(posedge clk); #1;
        check_val("after_done", {62'd0, done_o, stall_o}, 64'd0);
    endtask

    logic [63:0] held;

    initial begin
        reset = 1'b1; valid_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; flush_i = 1'b0;
        #12;
        check_val("reset_outputs", {62'd0, done_o, stall_o}, 64'd0);
        check_val("reset_result", result_o, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed vectors
        run_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd1, 64'h7FFF_FFFF, 64'd2);
        run_op(4'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        run_op(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        run_op(4'd3, 64'd5, 64'd0);
        run_op(4'd7, 64'd5, 64'd0);
        run_op(4'd4, 64'h8000_0000, 64'hFFFF_FFFF);
        run_op(4'd8, 64'h8000_0000, 64'hFFFF_FFFF);
        run_op(4'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(4'd9, 64'hFFFF_FFFF_8765_4321, 64'h1234_5678_0000_0000);
        run_op(4'd8, 64'h0000_0000_FFFF_FFF0, 64'd3);

        // Random operations, with some small or zero divisors.
        for (int i = 0; i < 12; i++) begin
            logic [3:0]  rop;
            logic [63:0] ra, rb;
            rop = 4'($urandom_range(0, 9));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rb = rb & 64'hFF;
                1: rb = '0;
                default: ;
            endcase
            run_op(rop, ra, rb);
        end

        // A reserved op is ignored.
        valid_i = 1'b1; op_i = 4'd12; a_i = 64'd9; b_i = 64'd3;
        #1;
        check_val("reserved_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #2;
        check_val("reserved_idle", {62'd0, done_o, stall_o}, 64'd0);
        valid_i = 1'b0;
        @(posedge clk); #1;

        // A flush at cycle 10 of a DIV aborts it.
        held = result_o;
        valid_i = 1'b1; op_i = 4'd2; a_i = 64'd1000; b_i = 64'd3;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        check_val("flush_stall", {62'd0, done_o, stall_o}, 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        check_val("flush_idle", {62'd0, done_o, stall_o}, 64'd0);
        begin
            int late_done;
            late_done = 0;
            repeat (70) begin
                @(posedge clk); #1;
                if (done_o) late_done++;
            end
            check_val("flush_no_done", 64'(late_done), 64'd0);
        end
        check_val("flush_result_held", result_o, held);
        run_op(4'd3, 64'd100, 64'd7);

        // An asynchronous reset in the middle of BUSY discards the op.
        valid_i = 1'b1; op_i = 4'd3; a_i = 64'd12345; b_i = 64'd17;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1; valid_i = 1'b0;
        #1;
        check_val("async_reset_flags", {62'd0, done_o, stall_o}, 64'd0);
        check_val("async_reset_result", result_o, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(4'd5, 64'd77, 64'd5);

        if (sb_q.size() != 0) check_val("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter: XLEN, 64, datapath width; only 64 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid_i  input  1  execute-stage instruction is a mul/div op.
REQ-005 op_i  input  4  0 MUL, 1 MULW, 2 DIV, 3 DIVU, 4 DIVW, 5 DIVUW, 6 REM, 7 REMU, 8 REMW, 9 REMUW; 10-15 reserved.
REQ-006 a_i  input  64  forwarded srca operand.
REQ-007 b_i  input  64  forwarded srcb operand.
REQ-008 flush_i  input  1  pipeline flush; aborts the current operation.
REQ-009 stall_o  output  1  freezes fetch/decode/execute while high.
REQ-010 done_o  output  1  result_o is valid this cycle.
REQ-011 result_o  output  64  operation result.

Function
REQ-012 States SHALL be IDLE, BUSY and DONE.
REQ-013 Start condition: IDLE & valid_i & !flush_i & op_i<=9; on start, latch op, operand magnitudes and result-sign flags, load iteration counter, and go to BUSY (or DONE for special cases).
REQ-014 stall_o SHALL be combinational: high when start is true or state==BUSY; low in IDLE without start and low in DONE.
REQ-015 Iteration count N SHALL be 64 for MUL/DIV/DIVU/REM/REMU and 32 for W ops; BUSY performs one shift-add (mul) or one restoring-subtract (div) step per cycle.
REQ-016 Timing: start at cycle 0, BUSY for cycles 1..N, DONE at cycle N+1; done_o is high for exactly one cycle, then the state returns to IDLE.
REQ-017 In DONE, valid_i SHALL NOT cause a start, because the instruction advances that cycle; a start is possible from the following IDLE cycle.
REQ-018 Signed ops SHALL compute on magnitudes and negate at DONE: quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
REQ-019 W ops SHALL use a[31:0] and b[31:0] (sign- or zero-extended per op) and return result[31:0] sign-extended to 64 bits.
REQ-020 MUL/MULW SHALL return the low XLEN / low 32 product bits.
REQ-021 Divide-by-zero SHALL go IDLE->DONE with no BUSY cycles: quotient = all ones; remainder = dividend (W ops: sign-extended low 32 bits).
REQ-022 Signed overflow (DIV: a=0x8000_0000_0000_0000, b=-1; DIVW: a[31:0]=0x8000_0000, b[31:0]=0xFFFF_FFFF) SHALL go IDLE->DONE: quotient = dividend; remainder = 0.
REQ-023 flush_i SHALL have priority over start and completion: in any state, next state is IDLE, done_o is not asserted, and stall_o goes low in the same cycle.
REQ-024 valid_i with a reserved op SHALL be ignored: no start, stall_o stays low.
REQ-025 result_o SHALL hold its last value outside DONE; operand changes while BUSY SHALL have no effect.

Reset
REQ-026 While reset is high: state = IDLE, counter = 0, stall_o = 0, done_o = 0, result_o = 0, independent of clk.
REQ-027 Reset asserted mid-BUSY SHALL discard the operation; after release the block is IDLE and accepts a new start on the first edge.

Verification
REQ-028 MUL a=7, b=0xFFFF_FFFF_FFFF_FFFD -> stall_o high cycles 0..64; done_o at cycle 65; result_o=0xFFFF_FFFF_FFFF_FFEB.
REQ-029 MULW a=0x7FFF_FFFF, b=2 -> done_o at cycle 33; result_o=0xFFFF_FFFF_FFFF_FFFE. DIV a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD; REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-030 DIVU a=5, b=0 -> done_o at cycle 1, result_o=0xFFFF_FFFF_FFFF_FFFF; REMU a=5, b=0 -> 5.
REQ-031 DIVW a=0x8000_0000, b=0xFFFF_FFFF -> done_o at cycle 1, result_o=0xFFFF_FFFF_8000_0000; REMW on the same operands -> 0.
REQ-032 DIV started, flush_i pulsed at cycle 10 -> stall_o=0 in cycle 10, IDLE at cycle 11, no done_o; then DIVU 100/7 -> 14 at cycle 65.
REQ-033 Reset pulsed asynchronously mid-BUSY -> stall_o, done_o and result_o are 0 before the next edge; valid_i held through DONE -> exactly one done_o pulse.
